// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: default control-bundle width, ID/EX stall FSM encoding,
// and the control-bundle bubble value.
package pipeline_pkg;

  localparam int unsigned CtrlWDefault = 8;

  typedef enum logic [0:0] {
    StRun  = 1'b0,
    StHold = 1'b1
  } id_ex_state_e;

  // Every bit of a bubbled control bundle takes this value.
  localparam logic CtrlBubbleBit = 1'b0;

endpackage

// File: rtl/id_load_use_detector.sv
// Combinational load-use detector: flags an ID instruction that depends on a load
// currently sitting in EX (ID/EX) or in MEM (EX/MEM).
module id_load_use_detector (
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_use_rs1_i,
  input  logic       id_use_rs2_i,
  input  logic       ex_valid_i,
  input  logic       ex_memread_i,
  input  logic [4:0] ex_rd_i,
  input  logic       mem_memread_i,
  input  logic       mem_regwrite_i,
  input  logic [4:0] mem_rd_i,
  output logic       haz_ex_o,
  output logic       haz_mem_o
);

  function automatic logic dep(input logic [4:0] rd);
    return id_valid_i && (rd != 5'd0) &&
           ((id_use_rs1_i && (id_rs1_i == rd)) || (id_use_rs2_i && (id_rs2_i == rd)));
  endfunction

  always_comb begin
    haz_ex_o  = ex_valid_i && ex_memread_i && dep(ex_rd_i);
    haz_mem_o = mem_memread_i && mem_regwrite_i && dep(mem_rd_i);
  end

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with operand select and load-use stall control.
// Optional ID_EX_PERF_EN adds stall and flush performance counters.
module id_ex_register
  import pipeline_pkg::*;
#(
  parameter int unsigned CTRL_W = CtrlWDefault
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ID_valid,
  input  logic [31:0]       ID_pc,
  input  logic [4:0]        ID_rs1,
  input  logic [4:0]        ID_rs2,
  input  logic              ID_use_rs1,
  input  logic              ID_use_rs2,
  input  logic [4:0]        ID_rd,
  input  logic [31:0]       ID_imm,
  input  logic [CTRL_W-1:0] ID_ctrl,
  input  logic              ID_regwrite,
  input  logic              ID_memread,
  input  logic              ID_memwrite,
  input  logic [31:0]       ID_rf_rs1_data,
  input  logic [31:0]       ID_rf_rs2_data,
  input  logic              ID_hazard_rs1_data_enable,
  input  logic              ID_hazard_rs2_data_enable,
  input  logic [31:0]       ID_hazard_rs1_data,
  input  logic [31:0]       ID_hazard_rs2_data,
  input  logic [4:0]        EX_MEM_rd,
  input  logic              EX_MEM_memread,
  input  logic              EX_MEM_regwrite,
  input  logic              EX_flush,
  output logic              ID_stall,
`ifdef ID_EX_PERF_EN
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt,
`endif
  output logic              ID_EX_valid,
  output logic [31:0]       ID_EX_pc,
  output logic [4:0]        ID_EX_rs1,
  output logic [4:0]        ID_EX_rs2,
  output logic [4:0]        ID_EX_rd,
  output logic [31:0]       ID_EX_imm,
  output logic [CTRL_W-1:0] ID_EX_ctrl,
  output logic              ID_EX_regwrite,
  output logic              ID_EX_memread,
  output logic              ID_EX_memwrite,
  output logic [31:0]       ID_EX_rs1_data,
  output logic [31:0]       ID_EX_rs2_data
);

  id_ex_state_e state_q, state_d;
  logic haz_ex, haz_mem, capture;
  logic [31:0] rs1_sel, rs2_sel;

  logic              valid_q, valid_d, rw_q, rw_d, mr_q, mr_d, mw_q, mw_d;
  logic [31:0]       pc_q, pc_d, imm_q, imm_d, d1_q, d1_d, d2_q, d2_d;
  logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  id_load_use_detector u_detector (
    .id_valid_i     (ID_valid),
    .id_rs1_i       (ID_rs1),
    .id_rs2_i       (ID_rs2),
    .id_use_rs1_i   (ID_use_rs1),
    .id_use_rs2_i   (ID_use_rs2),
    .ex_valid_i     (valid_q),
    .ex_memread_i   (mr_q),
    .ex_rd_i        (rd_q),
    .mem_memread_i  (EX_MEM_memread),
    .mem_regwrite_i (EX_MEM_regwrite),
    .mem_rd_i       (EX_MEM_rd),
    .haz_ex_o       (haz_ex),
    .haz_mem_o      (haz_mem)
  );

  always_comb begin
    rs1_sel = (ID_rs1 == 5'd0) ? 32'd0 :
              (ID_hazard_rs1_data_enable ? ID_hazard_rs1_data : ID_rf_rs1_data);
    rs2_sel = (ID_rs2 == 5'd0) ? 32'd0 :
              (ID_hazard_rs2_data_enable ? ID_hazard_rs2_data : ID_rf_rs2_data);
  end

  // Flush wins over any stall: a killed instruction must never hold the front end.
  always_comb begin
    state_d  = state_q;
    ID_stall = 1'b0;
    capture  = 1'b0;
    if (EX_flush) begin
      state_d = StRun;
    end else if (state_q == StHold) begin
      ID_stall = 1'b1;
      state_d  = StRun;
    end else if (haz_ex) begin
      ID_stall = 1'b1;
      state_d  = StHold;
    end else if (haz_mem) begin
      ID_stall = 1'b1;
    end else begin
      capture = 1'b1;
    end
  end

  always_comb begin
    valid_d = 1'b0;
    pc_d    = '0;
    rs1_d   = '0;
    rs2_d   = '0;
    rd_d    = '0;
    imm_d   = '0;
    ctrl_d  = {CTRL_W{CtrlBubbleBit}};
    rw_d    = 1'b0;
    mr_d    = 1'b0;
    mw_d    = 1'b0;
    d1_d    = '0;
    d2_d    = '0;
    if (capture) begin
      valid_d = ID_valid;
      pc_d    = ID_pc;
      rs1_d   = ID_rs1;
      rs2_d   = ID_rs2;
      rd_d    = ID_rd;
      imm_d   = ID_imm;
      ctrl_d  = ID_ctrl;
      rw_d    = ID_regwrite;
      mr_d    = ID_memread;
      mw_d    = ID_memwrite;
      d1_d    = rs1_sel;
      d2_d    = rs2_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      valid_q <= 1'b0;
      pc_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      ctrl_q  <= '0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      d1_q    <= '0;
      d2_q    <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      imm_q   <= imm_d;
      ctrl_q  <= ctrl_d;
      rw_q    <= rw_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
    end
  end

`ifdef ID_EX_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (ID_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (EX_flush && ID_valid) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

  assign ID_EX_valid    = valid_q;
  assign ID_EX_pc       = pc_q;
  assign ID_EX_rs1      = rs1_q;
  assign ID_EX_rs2      = rs2_q;
  assign ID_EX_rd       = rd_q;
  assign ID_EX_imm      = imm_q;
  assign ID_EX_ctrl     = ctrl_q;
  assign ID_EX_regwrite = rw_q;
  assign ID_EX_memread  = mr_q;
  assign ID_EX_memwrite = mw_q;
  assign ID_EX_rs1_data = d1_q;
  assign ID_EX_rs2_data = d2_q;

endmodule

// File: tb/tb_id_ex_register.sv
// Self-checking bench for id_ex_register: directed load-use/forward/flush scenarios plus a
// randomized stream checked against a behavioural model (ID_EX_PERF_EN also checks counters).
module tb_id_ex_register;

  localparam int unsigned CW = 8;

  logic clk, rst_n;
  logic ID_valid, ID_use_rs1, ID_use_rs2, ID_regwrite, ID_memread, ID_memwrite;
  logic [31:0] ID_pc, ID_imm, ID_rf_rs1_data, ID_rf_rs2_data;
  logic [31:0] ID_hazard_rs1_data, ID_hazard_rs2_data;
  logic ID_hazard_rs1_data_enable, ID_hazard_rs2_data_enable;
  logic [4:0] ID_rs1, ID_rs2, ID_rd, EX_MEM_rd;
  logic [CW-1:0] ID_ctrl;
  logic EX_MEM_memread, EX_MEM_regwrite, EX_flush;
  logic ID_stall;
  logic ID_EX_valid, ID_EX_regwrite, ID_EX_memread, ID_EX_memwrite;
  logic [31:0] ID_EX_pc, ID_EX_imm, ID_EX_rs1_data, ID_EX_rs2_data;
  logic [4:0] ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
  logic [CW-1:0] ID_EX_ctrl;
`ifdef ID_EX_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  id_ex_register #(.CTRL_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ID_valid(ID_valid), .ID_pc(ID_pc), .ID_rs1(ID_rs1),
    .ID_rs2(ID_rs2), .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2), .ID_rd(ID_rd),
    .ID_imm(ID_imm), .ID_ctrl(ID_ctrl), .ID_regwrite(ID_regwrite), .ID_memread(ID_memread),
    .ID_memwrite(ID_memwrite), .ID_rf_rs1_data(ID_rf_rs1_data),
    .ID_rf_rs2_data(ID_rf_rs2_data), .ID_hazard_rs1_data_enable(ID_hazard_rs1_data_enable),
    .ID_hazard_rs2_data_enable(ID_hazard_rs2_data_enable),
    .ID_hazard_rs1_data(ID_hazard_rs1_data), .ID_hazard_rs2_data(ID_hazard_rs2_data),
    .EX_MEM_rd(EX_MEM_rd), .EX_MEM_memread(EX_MEM_memread), .EX_MEM_regwrite(EX_MEM_regwrite),
    .EX_flush(EX_flush), .ID_stall(ID_stall),
`ifdef ID_EX_PERF_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
    .ID_EX_valid(ID_EX_valid), .ID_EX_pc(ID_EX_pc), .ID_EX_rs1(ID_EX_rs1),
    .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd), .ID_EX_imm(ID_EX_imm),
    .ID_EX_ctrl(ID_EX_ctrl), .ID_EX_regwrite(ID_EX_regwrite),
    .ID_EX_memread(ID_EX_memread), .ID_EX_memwrite(ID_EX_memwrite),
    .ID_EX_rs1_data(ID_EX_rs1_data), .ID_EX_rs2_data(ID_EX_rs2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: what the EX stage should hold, and whether the previous cycle's stall
  // was caused by a load in EX (which still sits one stage upstream of WB next cycle).
  typedef struct {
    bit          valid, rw, mr, mw;
    bit [31:0]   pc, imm, d1, d2;
    bit [4:0]    rs1, rs2, rd;
    bit [CW-1:0] ctrl;
  } ex_t;
  ex_t       m_ex;
  bit        m_after_ex_load;
  bit [31:0] m_pstall, m_pflush;

  function automatic bit reads(input bit [4:0] rd);
    return ID_valid && rd != 0 && ((ID_use_rs1 && ID_rs1 == rd) || (ID_use_rs2 && ID_rs2 == rd));
  endfunction

  function automatic bit [31:0] pick(input bit [4:0] idx, input bit en, input bit [31:0] fw,
                                     input bit [31:0] rf);
    if (idx == 0) return 0;
    return en ? fw : rf;
  endfunction

  task automatic model_reset();
    m_ex = '{default: 0};
    m_after_ex_load = 0;
    m_pstall = 0;
    m_pflush = 0;
  endtask

  task automatic clear_inputs();
    {ID_valid, ID_use_rs1, ID_use_rs2, ID_regwrite, ID_memread, ID_memwrite} = '0;
    {ID_pc, ID_imm, ID_rf_rs1_data, ID_rf_rs2_data, ID_hazard_rs1_data, ID_hazard_rs2_data} = '0;
    {ID_hazard_rs1_data_enable, ID_hazard_rs2_data_enable} = '0;
    {ID_rs1, ID_rs2, ID_rd, EX_MEM_rd} = '0;
    ID_ctrl = '0;
    {EX_MEM_memread, EX_MEM_regwrite, EX_flush} = '0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ":valid"}, ID_EX_valid, m_ex.valid);
    check({tag, ":pc"}, ID_EX_pc, m_ex.pc);
    check({tag, ":rs1"}, ID_EX_rs1, m_ex.rs1);
    check({tag, ":rs2"}, ID_EX_rs2, m_ex.rs2);
    check({tag, ":rd"}, ID_EX_rd, m_ex.rd);
    check({tag, ":imm"}, ID_EX_imm, m_ex.imm);
    check({tag, ":ctrl"}, ID_EX_ctrl, m_ex.ctrl);
    check({tag, ":rw"}, ID_EX_regwrite, m_ex.rw);
    check({tag, ":mr"}, ID_EX_memread, m_ex.mr);
    check({tag, ":mw"}, ID_EX_memwrite, m_ex.mw);
    check({tag, ":d1"}, ID_EX_rs1_data, m_ex.d1);
    check({tag, ":d2"}, ID_EX_rs2_data, m_ex.d2);
`ifdef ID_EX_PERF_EN
    check({tag, ":pstall"}, perf_stall_cnt, m_pstall);
    check({tag, ":pflush"}, perf_flush_cnt, m_pflush);
`endif
  endtask

  // Called at a negedge with inputs applied; checks the stall, clocks, checks the EX stage and
  // returns at the next negedge.
  task automatic step(input string tag, output bit stalled);
    bit dep_ex, dep_mem;
    #1;
    dep_ex  = m_ex.valid && m_ex.mr && reads(m_ex.rd);
    dep_mem = EX_MEM_memread && EX_MEM_regwrite && reads(EX_MEM_rd);
    stalled = !EX_flush && (m_after_ex_load || dep_ex || dep_mem);
    check({tag, ":stall"}, ID_stall, stalled);
    m_pstall += stalled ? 1 : 0;
    m_pflush += (EX_flush && ID_valid) ? 1 : 0;
    m_after_ex_load = !EX_flush && !m_after_ex_load && dep_ex;
    if (EX_flush || stalled) m_ex = '{default: 0};
    else begin
      m_ex.valid = ID_valid;   m_ex.pc  = ID_pc;  m_ex.rs1 = ID_rs1; m_ex.rs2 = ID_rs2;
      m_ex.rd    = ID_rd;      m_ex.imm = ID_imm; m_ex.ctrl = ID_ctrl;
      m_ex.rw    = ID_regwrite; m_ex.mr = ID_memread; m_ex.mw = ID_memwrite;
      m_ex.d1 = pick(ID_rs1, ID_hazard_rs1_data_enable, ID_hazard_rs1_data, ID_rf_rs1_data);
      m_ex.d2 = pick(ID_rs2, ID_hazard_rs2_data_enable, ID_hazard_rs2_data, ID_rf_rs2_data);
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    #2;
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs(tag);
    check({tag, ":stall"}, ID_stall, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_load(input bit [4:0] rd);
    clear_inputs();
    ID_valid = 1; ID_memread = 1; ID_regwrite = 1; ID_rd = rd; ID_rs1 = 2; ID_use_rs1 = 1;
    ID_pc = 32'h100; ID_ctrl = 8'h11;
  endtask

  task automatic set_add(input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2);
    clear_inputs();
    ID_valid = 1; ID_regwrite = 1; ID_rd = rd; ID_rs1 = rs1; ID_rs2 = rs2;
    ID_use_rs1 = 1; ID_use_rs2 = 1; ID_pc = 32'h104; ID_ctrl = 8'h22;
    ID_rf_rs1_data = 32'd5; ID_rf_rs2_data = 32'd7;
  endtask

  task automatic set_load_in_mem(input bit [4:0] rd);
    EX_MEM_rd = rd; EX_MEM_memread = 1; EX_MEM_regwrite = 1;
  endtask

  bit st;
  int nst;

  initial begin
    clear_inputs();
    model_reset();
    rst_n = 1'b0;
    @(negedge clk);
    do_reset("rst0");

    set_add(5'd4, 5'd3, 5'd0);
    step("t2_add", st);
    check("t2_never_stall", st, 0);
    check("t2_rs1_data", ID_EX_rs1_data, 32'd5);
    check("t2_valid", ID_EX_valid, 1);

    do_reset("t1_reset_mid");

    set_add(5'd8, 5'd1, 5'd3);
    ID_hazard_rs2_data_enable = 1; ID_hazard_rs2_data = 32'hDEAD;
    step("t3_fwd", st);
    check("t3_rs2_fwd", ID_EX_rs2_data, 32'hDEAD);
    ID_rs2 = 5'd0;
    step("t3_x0", st);
    check("t3_rs2_x0", ID_EX_rs2_data, 32'd0);

    set_load(5'd5);
    step("t4_lw", st);
    set_add(5'd6, 5'd5, 5'd1);
    nst = 0;
    step("t4_s1", st); nst += int'(st);
    set_load_in_mem(5'd5);
    step("t4_s2", st); nst += int'(st);
    EX_MEM_memread = 0; EX_MEM_regwrite = 0;
    step("t4_cap", st); nst += int'(st);
    check("t4_stall_cycles", nst, 2);
    check("t4_captured_rd", ID_EX_rd, 6);

    set_load(5'd5);
    step("t5_lw", st);
    clear_inputs();
    step("t5_nop", st);
    set_add(5'd6, 5'd5, 5'd1);
    set_load_in_mem(5'd5);
    nst = 0;
    step("t5_s1", st); nst += int'(st);
    EX_MEM_memread = 0; EX_MEM_regwrite = 0;
    step("t5_cap", st); nst += int'(st);
    check("t5_stall_cycles", nst, 1);
    check("t5_captured_valid", ID_EX_valid, 1);

    do_reset("rst6");
    set_load(5'd5);
    step("t6_lw", st);
    set_add(5'd6, 5'd5, 5'd1);
    step("t6_s1", st);
    check("t6_first_stall", st, 1);
    set_load_in_mem(5'd5);
    EX_flush = 1;
    step("t6_flush", st);
    check("t6_flush_no_stall", st, 0);
    check("t6_bubble", ID_EX_valid, 0);
`ifdef ID_EX_PERF_EN
    check("t6_perf_stall", perf_stall_cnt, 1);
    check("t6_perf_flush", perf_flush_cnt, 1);
`endif
    clear_inputs();
    step("t6_after", st);

    for (int i = 0; i < 400; i++) begin
      ID_valid = ($urandom_range(4) != 0);
      ID_pc = $urandom; ID_imm = $urandom; ID_ctrl = CW'($urandom);
      ID_rs1 = 5'($urandom_range(3)); ID_rs2 = 5'($urandom_range(3));
      ID_rd = 5'($urandom_range(3));
      ID_use_rs1 = $urandom_range(1); ID_use_rs2 = $urandom_range(1);
      ID_regwrite = $urandom_range(1); ID_memread = ($urandom_range(2) == 0);
      ID_memwrite = $urandom_range(1);
      ID_rf_rs1_data = $urandom; ID_rf_rs2_data = $urandom;
      ID_hazard_rs1_data = $urandom; ID_hazard_rs2_data = $urandom;
      ID_hazard_rs1_data_enable = $urandom_range(1);
      ID_hazard_rs2_data_enable = $urandom_range(1);
      EX_MEM_rd = 5'($urandom_range(3));
      EX_MEM_memread = ($urandom_range(3) == 0); EX_MEM_regwrite = $urandom_range(1);
      EX_flush = ($urandom_range(9) == 0);
      step("rnd", st);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
